// File: rtl/poly_eval_horner.sv
// -----------------------------------------------------------------------------
// poly_eval_horner
//
// Evaluates y = c_N*x^N + ... + c_1*x + c_0 (mod 2^WIDTH) by Horner's method
// on a single shared multiply/add ALU. Coefficients (c_N first, down to c_0)
// and then x are loaded serially with a press/release handshake on go.
//
// Parameters:
//   WIDTH   data width of coefficients, x, accumulator and result
//   DEGREE  polynomial degree N (1..15); DEGREE+1 coefficients are stored
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   go            load strobe: high captures data_in, low advances to next item
//   data_in       coefficient or x value to capture
//   data_result   registered polynomial result
//   result_valid  high while a completed result is held and no new load started
//   busy          high during evaluation; go is ignored while busy
// -----------------------------------------------------------------------------
module poly_eval_horner #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEGREE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_result,
    output logic             result_valid,
    output logic             busy
);

    // Index wide enough to hold DEGREE; one bit minimum for DEGREE = 1.
    localparam int unsigned IdxW = (DEGREE < 2) ? 1 : $clog2(DEGREE + 1);
    localparam logic [IdxW-1:0] IdxTop   = IdxW'(DEGREE);
    localparam logic [IdxW-1:0] IdxTopM1 = IdxW'(DEGREE - 1);

    typedef enum logic [2:0] {
        StLoad,
        StLoadWait,
        StLoadX,
        StLoadXWait,
        StInit,
        StMul,
        StAdd,
        StDone
    } state_e;

    state_e state_q, state_d;

    // -------------------------------------------------------------------------
    // Datapath storage
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] coef_q [DEGREE+1];
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] data_result_q;
    logic [IdxW-1:0]  idx_q;

    // -------------------------------------------------------------------------
    // Control signals from the FSM to the datapath
    // -------------------------------------------------------------------------
    logic coef_we;        // write coefficient register idx_q from data_in
    logic x_we;           // write x from data_in
    logic acc_init;       // acc <= c_DEGREE
    logic acc_step;       // acc <= ALU result
    logic op_mul;         // ALU select: 1 = acc*x, 0 = acc + c_idx
    logic idx_dec;        // idx <= idx - 1
    logic idx_to_top;     // idx <= DEGREE (ready for next load)
    logic idx_to_top_m1;  // idx <= DEGREE-1 (first ADD uses c_(DEGREE-1))
    logic res_we;         // data_result <= ALU result
    logic idx_is_zero;

    assign idx_is_zero = (idx_q == '0);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state, datapath controls and status outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        coef_we       = 1'b0;
        x_we          = 1'b0;
        acc_init      = 1'b0;
        acc_step      = 1'b0;
        op_mul        = 1'b0;
        idx_dec       = 1'b0;
        idx_to_top    = 1'b0;
        idx_to_top_m1 = 1'b0;
        res_we        = 1'b0;
        busy          = 1'b0;
        result_valid  = 1'b0;

        unique case (state_q)
            // StDone doubles as the load state for c_DEGREE; idx already
            // points at DEGREE when the run finishes.
            StLoad, StDone: begin
                result_valid = (state_q == StDone);
                if (go) begin
                    coef_we = 1'b1;
                    state_d = StLoadWait;
                end
            end

            // The register keeps tracking data_in while go stays high, so the
            // value on the last go-high cycle is the one kept.
            StLoadWait: begin
                if (go) begin
                    coef_we = 1'b1;
                end else if (idx_is_zero) begin
                    state_d = StLoadX;
                end else begin
                    idx_dec = 1'b1;
                    state_d = StLoad;
                end
            end

            StLoadX: begin
                if (go) begin
                    x_we    = 1'b1;
                    state_d = StLoadXWait;
                end
            end

            StLoadXWait: begin
                if (go) begin
                    x_we = 1'b1;
                end else begin
                    state_d = StInit;
                end
            end

            StInit: begin
                busy          = 1'b1;
                acc_init      = 1'b1;
                idx_to_top_m1 = 1'b1;
                state_d       = StMul;
            end

            StMul: begin
                busy     = 1'b1;
                acc_step = 1'b1;
                op_mul   = 1'b1;
                state_d  = StAdd;
            end

            StAdd: begin
                busy     = 1'b1;
                acc_step = 1'b1;
                if (idx_is_zero) begin
                    res_we     = 1'b1;
                    idx_to_top = 1'b1;
                    state_d    = StDone;
                end else begin
                    idx_dec = 1'b1;
                    state_d = StMul;
                end
            end

            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Shared ALU: one multiplier and one adder, selected by op_mul
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] coef_sel;
    logic [WIDTH-1:0] alu_out;

    always_comb begin
        coef_sel = '0;
        for (int i = 0; i < DEGREE + 1; i++) begin
            if (idx_q == IdxW'(i)) begin
                coef_sel = coef_q[i];
            end
        end
    end

    always_comb begin
        if (op_mul) begin
            alu_out = WIDTH'(acc_q * x_q);
        end else begin
            alu_out = WIDTH'(acc_q + coef_sel);
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEGREE + 1; i++) begin
                coef_q[i] <= '0;
            end
            x_q           <= '0;
            acc_q         <= '0;
            idx_q         <= IdxTop;
            data_result_q <= '0;
        end else begin
            if (coef_we) begin
                for (int i = 0; i < DEGREE + 1; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        coef_q[i] <= data_in;
                    end
                end
            end

            if (x_we) begin
                x_q <= data_in;
            end

            if (acc_init) begin
                acc_q <= coef_q[DEGREE];
            end else if (acc_step) begin
                acc_q <= alu_out;
            end

            if (idx_to_top) begin
                idx_q <= IdxTop;
            end else if (idx_to_top_m1) begin
                idx_q <= IdxTopM1;
            end else if (idx_dec) begin
                idx_q <= idx_q - 1'b1;
            end

            // Only the final ADD writes the result, so a partial value is
            // never visible.
            if (res_we) begin
                data_result_q <= alu_out;
            end
        end
    end

    assign data_result = data_result_q;

endmodule

// File: tb/tb_poly_eval_horner.sv
// -----------------------------------------------------------------------------
// tb_poly_eval_horner
//
// Bench for poly_eval_horner with three instances:
//   a: WIDTH=8,  DEGREE=2
//   b: WIDTH=16, DEGREE=4
//   c: WIDTH=8,  DEGREE=1
// Expected results come from direct power-sum evaluation of the polynomial.
// -----------------------------------------------------------------------------
module tb_poly_eval_horner;

    typedef int unsigned coef_t [16];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go_a = 1'b0, go_b = 1'b0, go_c = 1'b0;
    logic [7:0]  din_a = '0, din_c = '0;
    logic [15:0] din_b = '0;
    logic [7:0]  res_a, res_c;
    logic [15:0] res_b;
    logic        valid_a, valid_b, valid_c;
    logic        busy_a, busy_b, busy_c;

    int errors = 0;
    int checks = 0;
    int unsigned prev [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    poly_eval_horner #(.WIDTH(8), .DEGREE(2)) dut_a (
        .clk(clk), .reset(reset), .go(go_a), .data_in(din_a),
        .data_result(res_a), .result_valid(valid_a), .busy(busy_a)
    );

    poly_eval_horner #(.WIDTH(16), .DEGREE(4)) dut_b (
        .clk(clk), .reset(reset), .go(go_b), .data_in(din_b),
        .data_result(res_b), .result_valid(valid_b), .busy(busy_b)
    );

    poly_eval_horner #(.WIDTH(8), .DEGREE(1)) dut_c (
        .clk(clk), .reset(reset), .go(go_c), .data_in(din_c),
        .data_result(res_c), .result_valid(valid_c), .busy(busy_c)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned get_res(input int inst);
        case (inst)
            0:       return {24'd0, res_a};
            1:       return {16'd0, res_b};
            default: return {24'd0, res_c};
        endcase
    endfunction

    function automatic int unsigned get_valid(input int inst);
        case (inst)
            0:       return {31'd0, valid_a};
            1:       return {31'd0, valid_b};
            default: return {31'd0, valid_c};
        endcase
    endfunction

    function automatic int unsigned get_busy(input int inst);
        case (inst)
            0:       return {31'd0, busy_a};
            1:       return {31'd0, busy_b};
            default: return {31'd0, busy_c};
        endcase
    endfunction

    task automatic set_in(input int inst, input logic g, input int unsigned v);
        case (inst)
            0: begin go_a = g; din_a = v[7:0];  end
            1: begin go_b = g; din_b = v[15:0]; end
            default: begin go_c = g; din_c = v[7:0]; end
        endcase
    endtask

    // Polynomial value as a plain sum of c_i * x^i, reduced mod 2^w.
    function automatic int unsigned model(input int deg, input int w, input coef_t c,
                                          input int unsigned x);
        longint unsigned mask, sum, term;
        mask = (64'd1 << w) - 1;
        sum  = 0;
        for (int i = 0; i <= deg; i++) begin
            term = c[i] & mask;
            for (int j = 0; j < i; j++) term = (term * x) & mask;
            sum = (sum + term) & mask;
        end
        return sum[31:0];
    endfunction

    // One press (one cycle high) and release (one cycle low), driven at negedge.
    task automatic load_item(input int inst, input int unsigned v);
        set_in(inst, 1'b1, v);
        @(negedge clk);
        set_in(inst, 1'b0, v);
        @(negedge clk);
    endtask

    task automatic load_poly(input int inst, input int deg, input coef_t c,
                             input int unsigned x, input bit skip_top);
        for (int k = deg; k >= 0; k--) begin
            if (!(skip_top && k == deg)) load_item(inst, c[k]);
        end
        load_item(inst, x);
    endtask

    // Called right after the x release: the DUT is in its first evaluation
    // cycle. Counts cycles until result_valid and checks result and latency.
    task automatic wait_check(input int inst, input int deg, input int unsigned exp,
                              input string tag, input bit pulse);
        int lat;
        lat = -1;
        check({tag, "/busy_init"}, get_busy(inst), 1);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (pulse && inst == 0) begin
                if (i == 1) begin
                    check({tag, "/busy_mul"}, get_busy(inst), 1);
                    go_a = 1'b1;
                    din_a = 8'hA5;
                end
                if (i == 3) go_a = 1'b0;
            end
            if (i == 2 * deg) begin
                check({tag, "/valid_pre"}, get_valid(inst), 0);
                check({tag, "/res_hold"}, get_res(inst), prev[inst]);
            end
            if (get_valid(inst) == 1) begin
                lat = i;
                break;
            end
        end
        check({tag, "/latency"}, lat, 1 + 2 * deg);
        check({tag, "/result"}, get_res(inst), exp);
        check({tag, "/busy_done"}, get_busy(inst), 0);
        prev[inst] = exp;
    endtask

    task automatic check_idle_zero(input string tag);
        for (int n = 0; n < 3; n++) begin
            check({tag, "/res"}, get_res(n), 0);
            check({tag, "/valid"}, get_valid(n), 0);
            check({tag, "/busy"}, get_busy(n), 0);
        end
        prev = '{0, 0, 0};
    endtask

    initial begin
        coef_t c;
        int unsigned x, e;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic: 1*16 + 2*4 + 3 = 27
        c = '{default: 0}; c[2] = 1; c[1] = 2; c[0] = 3;
        load_poly(0, 2, c, 4, 0);
        wait_check(0, 2, 27, "basic", 0);

        // Reset while loading c0
        load_item(0, 1);
        load_item(0, 2);
        set_in(0, 1'b1, 3);
        @(negedge clk);
        reset = 1'b1;
        set_in(0, 1'b0, 0);
        @(negedge clk);
        check_idle_zero("rst_load");
        reset = 1'b0;
        @(negedge clk);
        load_poly(0, 2, c, 4, 0);
        wait_check(0, 2, 27, "after_rst_load", 0);

        // Reset mid-MUL
        load_poly(0, 2, c, 4, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("rst_mul");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_mul/no_partial", get_valid(0), 0);
        load_poly(0, 2, c, 4, 0);
        wait_check(0, 2, 27, "after_rst_mul", 0);

        // Wrap cases
        c = '{default: 0}; c[2] = 255;
        load_poly(0, 2, c, 2, 0);
        wait_check(0, 2, 252, "wrap_a", 0);
        c = '{default: 0}; c[2] = 16; c[0] = 1;
        load_poly(0, 2, c, 16, 0);
        wait_check(0, 2, 1, "wrap_b", 0);

        // go held 10 cycles on c1, data_in changes to 9 on the last cycle
        load_item(0, 2);
        set_in(0, 1'b1, 5);
        repeat (9) @(negedge clk);
        set_in(0, 1'b1, 9);
        @(negedge clk);
        set_in(0, 1'b0, 0);
        @(negedge clk);
        load_item(0, 3);
        load_item(0, 2);
        wait_check(0, 2, 29, "held_go", 0);

        // go pulsed during evaluation is ignored
        c = '{default: 0}; c[2] = 7; c[1] = 6; c[0] = 5;
        load_poly(0, 2, c, 3, 0);
        wait_check(0, 2, 86, "pulse_eval", 1);

        // Press in LOAD_DONE: result_valid drops next cycle, result held
        check("done_press/valid_before", get_valid(0), 1);
        set_in(0, 1'b1, 1);
        @(negedge clk);
        check("done_press/valid_after", get_valid(0), 0);
        check("done_press/res_kept", get_res(0), 86);
        set_in(0, 1'b0, 0);
        @(negedge clk);
        c = '{default: 0}; c[2] = 1; c[1] = 2; c[0] = 3;
        load_poly(0, 2, c, 4, 1);
        wait_check(0, 2, 27, "done_press_run", 0);

        // DEGREE=4, WIDTH=16: x^4 + 5 at x=3
        c = '{default: 0}; c[4] = 1; c[0] = 5;
        load_poly(1, 4, c, 3, 0);
        wait_check(1, 4, 86, "deg4", 0);

        // DEGREE=1: 7x + 1 at x=6
        c = '{default: 0}; c[1] = 7; c[0] = 1;
        load_poly(2, 1, c, 6, 0);
        wait_check(2, 1, 43, "deg1", 0);

        // Random runs against the model, back to back with no reset
        for (int r = 0; r < 4; r++) begin
            c = '{default: 0};
            for (int k = 0; k <= 2; k++) c[k] = $urandom & 32'hFF;
            x = $urandom & 32'hFF;
            e = model(2, 8, c, x);
            load_poly(0, 2, c, x, 0);
            wait_check(0, 2, e, "rand_a", 0);

            c = '{default: 0};
            for (int k = 0; k <= 4; k++) c[k] = $urandom & 32'hFFFF;
            x = $urandom & 32'hFFFF;
            e = model(4, 16, c, x);
            load_poly(1, 4, c, x, 0);
            wait_check(1, 4, e, "rand_b", 0);

            c = '{default: 0};
            for (int k = 0; k <= 1; k++) c[k] = $urandom & 32'hFF;
            x = $urandom & 32'hFF;
            e = model(1, 8, c, x);
            load_poly(2, 1, c, x, 0);
            wait_check(2, 1, e, "rand_c", 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
